// File: rtl/rcv_pkg.sv
// Shared types and constants for the receive PHY deframer.
// Build option: RCV_SFD_CHECK_EN compiles in preamble/SFD hunting.
package rcv_pkg;

   localparam int CNT_W     = 16;
   localparam int RUNT_BIT  = 23;
   localparam int GIANT_BIT = 22;
   localparam int ODD_BIT   = 21;

   localparam logic [3:0] SFD_PRE_NIB = 4'h5;
   localparam logic [3:0] SFD_NIB     = 4'hD;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
`ifdef RCV_SFD_CHECK_EN
      ST_PREAMBLE = 2'd1,
`endif
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } rcv_state_e;

   function automatic logic [23:0] pack_ctrl(input logic runt, input logic giant,
                                             input logic odd, input logic [CNT_W-1:0] count);
      logic [23:0] ctrl;
      ctrl            = '0;
      ctrl[RUNT_BIT]  = runt;
      ctrl[GIANT_BIT] = giant;
      ctrl[ODD_BIT]   = odd;
      ctrl[15:0]      = count;
      return ctrl;
   endfunction

endpackage

// File: rtl/rcv_nibble_pack.sv
// Pairs incoming nibbles into bytes (low nibble first) and reports an unpaired nibble.
// A take coincident with clear always starts a fresh pair.
module rcv_nibble_pack (
   input  logic       clk_phy,
   input  logic       reset,
   input  logic       take,
   input  logic       clear,
   input  logic [3:0] nib,
   output logic [7:0] pair_byte,
   output logic       pair_done,
   output logic       odd_pend
);

   logic [3:0] lo_q;
   logic       pend_q;

   always_ff @(posedge clk_phy) begin
      if (reset) begin
         lo_q   <= 4'd0;
         pend_q <= 1'b0;
      end else if (take && (clear || !pend_q)) begin
         lo_q   <= nib;
         pend_q <= 1'b1;
      end else if (take || clear) begin
         pend_q <= 1'b0;
      end
   end

   assign pair_done = take & pend_q & ~clear;
   assign pair_byte = {nib, lo_q};
   assign odd_pend  = pend_q;

endmodule

// File: rtl/rcv_phy_deframer.sv
// Nibble-stream receive deframer: optional SFD hunt, byte assembly, length/status report.
// Build option: RCV_SFD_CHECK_EN enables the PREAMBLE state (SFD hunting).
//
// state    | meaning
// ST_IDLE  | waiting for a phy_rx_dv rising edge
// ST_PREAM | hunting for 0x5 followed by 0xD (only with RCV_SFD_CHECK_EN)
// ST_DATA  | assembling and emitting bytes
// ST_DROP  | discarding nibbles until phy_rx_dv falls
module rcv_phy_deframer
   import rcv_pkg::*;
#(
   parameter int MIN_LEN = 64,
   parameter int MAX_LEN = 1518
) (
   input  logic        clk_phy,
   input  logic        reset,
   input  logic [3:0]  phy_data_in,
   input  logic        phy_rx_dv,
   output logic [7:0]  r_data_out,
   output logic        r_data_valid,
   output logic        r_frame_valid,
   output logic [23:0] r_ctrl_out
);

   rcv_state_e       state;
   logic             dv_q;
   logic             abort_q;
   logic             giant_q;
   logic [CNT_W-1:0] count;
   logic             rise;
   logic             at_max;
   logic             nib_take;
   logic             nib_clear;
   logic             pair_done;
   logic             odd_pend;
   logic [7:0]       pair_byte;
`ifdef RCV_SFD_CHECK_EN
   logic [3:0]       prev_nib;
`endif

   assign rise   = phy_rx_dv & ~dv_q;
   assign at_max = (count >= CNT_W'(MAX_LEN));

`ifdef RCV_SFD_CHECK_EN
   assign nib_take = (state == ST_DATA) && phy_rx_dv;
`else
   assign nib_take = ((state == ST_DATA) && phy_rx_dv) || ((state == ST_IDLE) && rise);
`endif
   assign nib_clear = (state != ST_DATA);

   rcv_nibble_pack u_pack (
      .clk_phy   (clk_phy),
      .reset     (reset),
      .take      (nib_take),
      .clear     (nib_clear),
      .nib       (phy_data_in),
      .pair_byte (pair_byte),
      .pair_done (pair_done),
      .odd_pend  (odd_pend)
   );

   always_ff @(posedge clk_phy) begin
      if (reset) begin
         state         <= ST_IDLE;
         // Treat the line as busy so a frame already in flight is never taken as a new rise.
         dv_q          <= 1'b1;
         abort_q       <= 1'b0;
         giant_q       <= 1'b0;
         count         <= '0;
         r_data_out    <= 8'd0;
         r_data_valid  <= 1'b0;
         r_frame_valid <= 1'b0;
         r_ctrl_out    <= 24'd0;
`ifdef RCV_SFD_CHECK_EN
         prev_nib      <= 4'd0;
`endif
      end else begin
         dv_q          <= phy_rx_dv;
         r_data_valid  <= 1'b0;
         r_frame_valid <= 1'b0;
         case (state)
            ST_IDLE: begin
               count   <= '0;
               giant_q <= 1'b0;
               abort_q <= 1'b0;
               if (rise) begin
`ifdef RCV_SFD_CHECK_EN
                  state    <= ST_PREAMBLE;
                  prev_nib <= phy_data_in;
`else
                  state    <= ST_DATA;
`endif
               end else if (phy_rx_dv) begin
                  state   <= ST_DROP;
                  abort_q <= 1'b1;
               end
            end
`ifdef RCV_SFD_CHECK_EN
            ST_PREAMBLE: begin
               prev_nib <= phy_data_in;
               if (!phy_rx_dv)
                  state <= ST_IDLE;
               else if (prev_nib == SFD_PRE_NIB && phy_data_in == SFD_NIB)
                  state <= ST_DATA;
            end
`endif
            ST_DATA: begin
               if (!phy_rx_dv) begin
                  state         <= ST_IDLE;
                  r_frame_valid <= 1'b1;
                  r_ctrl_out    <= pack_ctrl(count < CNT_W'(MIN_LEN), giant_q, odd_pend, count);
               end else if (pair_done) begin
                  if (at_max) begin
                     giant_q <= 1'b1;
                     state   <= ST_DROP;
                  end else begin
                     r_data_out   <= pair_byte;
                     r_data_valid <= 1'b1;
                     count        <= count + 16'd1;
                  end
               end
            end
            ST_DROP: begin
               if (!phy_rx_dv) begin
                  state <= ST_IDLE;
                  if (!abort_q) begin
                     r_frame_valid <= 1'b1;
                     r_ctrl_out    <= pack_ctrl(count < CNT_W'(MIN_LEN), giant_q, odd_pend, count);
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rcv_phy_deframer.sv
// Directed self-checking bench for rcv_phy_deframer (default parameters).
// Preamble/SFD is sent only when RCV_SFD_CHECK_EN is defined.
module tb_rcv_phy_deframer;

   logic        clk_phy = 1'b0;
   logic        reset;
   logic [3:0]  phy_data_in;
   logic        phy_rx_dv;
   logic [7:0]  r_data_out;
   logic        r_data_valid;
   logic        r_frame_valid;
   logic [23:0] r_ctrl_out;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          fv_cnt   = 0;
   int          overlap  = 0;
   logic [31:0] last_ctrl = 32'd0;
   logic [7:0]  rx_q[$];

   rcv_phy_deframer dut (
      .clk_phy       (clk_phy),
      .reset         (reset),
      .phy_data_in   (phy_data_in),
      .phy_rx_dv     (phy_rx_dv),
      .r_data_out    (r_data_out),
      .r_data_valid  (r_data_valid),
      .r_frame_valid (r_frame_valid),
      .r_ctrl_out    (r_ctrl_out)
   );

   always #5 clk_phy = ~clk_phy;

   always @(negedge clk_phy) begin
      if (r_data_valid) rx_q.push_back(r_data_out);
      if (r_frame_valid) begin
         fv_cnt++;
         last_ctrl = {8'd0, r_ctrl_out};
         if (r_data_valid) overlap++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic nib(input logic [3:0] n);
      @(negedge clk_phy);
      phy_rx_dv   = 1'b1;
      phy_data_in = n;
   endtask

   task automatic idle(input int k);
      repeat (k) begin
         @(negedge clk_phy);
         phy_rx_dv   = 1'b0;
         phy_data_in = 4'h0;
      end
   endtask

   task automatic preamble();
`ifdef RCV_SFD_CHECK_EN
      repeat (15) nib(4'h5);
      nib(4'hD);
`endif
   endtask

   task automatic send_bytes(input int first, input int last);
      logic [7:0] b;
      for (int k = first; k < last; k++) begin
         b = 8'(k);
         nib(b[3:0]);
         nib(b[7:4]);
      end
   endtask

   task automatic start_test();
      rx_q.delete();
      fv_cnt  = 0;
      overlap = 0;
   endtask

   function automatic int count_bad(input int period);
      int bad = 0;
      for (int i = 0; i < rx_q.size(); i++)
         if (rx_q[i] !== 8'(i % period)) bad++;
      return bad;
   endfunction

   initial begin
      reset       = 1'b1;
      phy_rx_dv   = 1'b0;
      phy_data_in = 4'h0;
      repeat (3) @(negedge clk_phy);
      check_eq("rst_data",  {24'd0, r_data_out}, 32'd0);
      check_eq("rst_dv",    {31'd0, r_data_valid}, 32'd0);
      check_eq("rst_fv",    {31'd0, r_frame_valid}, 32'd0);
      check_eq("rst_ctrl",  {8'd0, r_ctrl_out}, 32'd0);
      reset = 1'b0;
      idle(3);

      // 512-byte frame
      start_test();
      preamble();
      send_bytes(0, 512);
      idle(4);
      check_eq("f512_cnt",  rx_q.size(), 32'd512);
      check_eq("f512_bad",  count_bad(512), 32'd0);
      check_eq("f512_fv",   fv_cnt, 32'd1);
      check_eq("f512_ctrl", last_ctrl, 32'h000200);
      check_eq("f512_ovl",  overlap, 32'd0);
      check_eq("hold_data", {24'd0, r_data_out}, 32'hFF);
      check_eq("hold_ctrl", {8'd0, r_ctrl_out}, 32'h000200);

      // 40-byte runt
      start_test();
      preamble();
      send_bytes(0, 40);
      idle(4);
      check_eq("runt_cnt",  rx_q.size(), 32'd40);
      check_eq("runt_ctrl", last_ctrl, 32'h800028);

      // 2000-byte giant
      start_test();
      preamble();
      send_bytes(0, 2000);
      idle(4);
      check_eq("giant_cnt",  rx_q.size(), 32'd1518);
      check_eq("giant_bad",  count_bad(2000), 32'd0);
      check_eq("giant_fv",   fv_cnt, 32'd1);
      check_eq("giant_ctrl", last_ctrl, 32'h4005EE);

      // 64 bytes plus an unpaired nibble
      start_test();
      preamble();
      send_bytes(0, 64);
      nib(4'hA);
      idle(4);
      check_eq("odd_cnt",  rx_q.size(), 32'd64);
      check_eq("odd_ctrl", last_ctrl, 32'h200040);

`ifdef RCV_SFD_CHECK_EN
      // preamble without SFD
      start_test();
      repeat (10) nib(4'h5);
      idle(4);
      check_eq("nosfd_cnt", rx_q.size(), 32'd0);
      check_eq("nosfd_fv",  fv_cnt, 32'd0);
`else
      // single nibble frame: no byte, runt and odd
      start_test();
      nib(4'h3);
      idle(4);
      check_eq("one_nib_cnt",  rx_q.size(), 32'd0);
      check_eq("one_nib_ctrl", last_ctrl, 32'hA00000);
`endif

      // back-to-back 64-byte frames with a single idle cycle
      start_test();
      preamble();
      send_bytes(0, 64);
      idle(1);
      preamble();
      send_bytes(0, 64);
      idle(4);
      check_eq("b2b_fv",   fv_cnt, 32'd2);
      check_eq("b2b_cnt",  rx_q.size(), 32'd128);
      check_eq("b2b_bad",  count_bad(64), 32'd0);
      check_eq("b2b_ctrl", last_ctrl, 32'h000040);

      // reset mid-frame with phy_rx_dv held high, then a back-to-back frame
      start_test();
      preamble();
      send_bytes(0, 100);
      @(negedge clk_phy);
      reset       = 1'b1;
      phy_data_in = 4'h4;
      @(negedge clk_phy);
      rx_q.delete();
      check_eq("mrst_data", {24'd0, r_data_out}, 32'd0);
      check_eq("mrst_dv",   {31'd0, r_data_valid}, 32'd0);
      check_eq("mrst_ctrl", {8'd0, r_ctrl_out}, 32'd0);
      @(negedge clk_phy);
      reset = 1'b0;
      send_bytes(100, 512);
      idle(1);
      preamble();
      send_bytes(0, 64);
      idle(4);
      check_eq("mrst_fv",    fv_cnt, 32'd1);
      check_eq("mrst_cnt",   rx_q.size(), 32'd64);
      check_eq("mrst_bad",   count_bad(64), 32'd0);
      check_eq("mrst_ctrl2", last_ctrl, 32'h000040);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
